// File: rtl/kf8259_host_pkg.sv
// Shared types and constants for the 8259 host-side bus master.
package kf8259_host_pkg;

  // Phases of one register-bus access.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_RECOVERY
  } bus_state_t;

  // Position within the ICW1..ICW4 initialization sequence.
  typedef enum logic [2:0] {
    STEP_ICW1,
    STEP_ICW2,
    STEP_ICW3,
    STEP_ICW4,
    STEP_DONE
  } init_step_t;

  // ICW1 bit positions.
  localparam int IC4     = 0;  // ICW4 will follow
  localparam int SNGL    = 1;  // single PIC, so no ICW3
  localparam int ICW1_ID = 4;  // marks the byte as ICW1 when A0=0

  // Word that follows the current one, skipping ICW3/ICW4 as ICW1 dictates.
  function automatic init_step_t next_init_step(input init_step_t step,
                                                input logic [7:0] icw1);
    init_step_t nxt;
    nxt = STEP_DONE;
    case (step)
      STEP_ICW1: nxt = STEP_ICW2;
      STEP_ICW2: nxt = !icw1[SNGL] ? STEP_ICW3 : (icw1[IC4] ? STEP_ICW4 : STEP_DONE);
      STEP_ICW3: nxt = icw1[IC4] ? STEP_ICW4 : STEP_DONE;
      default:   nxt = STEP_DONE;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/kf8259_host_bus_cycle.sv
// Timer for a single 8259 bus access: SETUP -> STROBE -> HOLD -> RECOVERY.
// A start pulse in IDLE latches the access; done flags the final RECOVERY cycle.
module kf8259_host_bus_cycle
  import kf8259_host_pkg::*;
#(
  parameter int SETUP_CYCLES    = 1,
  parameter int STROBE_CYCLES   = 2,
  parameter int HOLD_CYCLES     = 1,
  parameter int RECOVERY_CYCLES = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       start_write,
  input  logic       start_address,
  input  logic [7:0] start_data,
  output logic       idle,
  output logic       done,
  output logic       chip_select_n,
  output logic       read_enable_n,
  output logic       write_enable_n,
  output logic       address,
  output logic [7:0] data_bus_out,
  output logic       data_bus_io,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  input  logic [7:0] data_bus_in
);

  localparam int MAX_AB     = (SETUP_CYCLES > STROBE_CYCLES) ? SETUP_CYCLES : STROBE_CYCLES;
  localparam int MAX_CD     = (HOLD_CYCLES > RECOVERY_CYCLES) ? HOLD_CYCLES : RECOVERY_CYCLES;
  localparam int MAX_CYCLES = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

  bus_state_t       state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             write_q, address_q;
  logic [7:0]       data_q;
  logic             last_strobe;

  function automatic logic [CNT_W-1:0] load(input int n);
    return CNT_W'(n - 1);
  endfunction

  assign last_strobe = (state == ST_STROBE) && (cnt == '0);

  // State register and phase down-counter.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Latch direction, A0 and write data when an access is accepted.
  always_ff @(posedge clock) begin
    if (reset) begin
      write_q   <= 1'b0;
      address_q <= 1'b0;
      data_q    <= '0;
    end else if (start && state == ST_IDLE) begin
      write_q   <= start_write;
      address_q <= start_address;
      data_q    <= start_data;
    end
  end

  // Capture read data on the last STROBE cycle; flag it the following cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= last_strobe && !write_q;
      if (last_strobe && !write_q) rsp_data <= data_bus_in;
    end
  end

  // Next phase: each phase runs for its parameter count, then hands over.
  // NOTE: defaults first in always_comb so no path leaves a signal unassigned (no latches).
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      ST_IDLE: if (start) begin
        state_next = ST_SETUP;
        cnt_next   = load(SETUP_CYCLES);
      end
      ST_SETUP: if (cnt == '0) begin
        state_next = ST_STROBE;
        cnt_next   = load(STROBE_CYCLES);
      end else cnt_next = cnt - 1'b1;
      ST_STROBE: if (cnt == '0) begin
        state_next = ST_HOLD;
        cnt_next   = load(HOLD_CYCLES);
      end else cnt_next = cnt - 1'b1;
      ST_HOLD: if (cnt == '0) begin
        state_next = ST_RECOVERY;
        cnt_next   = load(RECOVERY_CYCLES);
      end else cnt_next = cnt - 1'b1;
      ST_RECOVERY: if (cnt == '0) begin
        state_next = ST_IDLE;
        cnt_next   = '0;
      end else cnt_next = cnt - 1'b1;
      default: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Bus pin levels per phase; CS_n stays low through HOLD so the PIC sees WR_n rise.
  always_comb begin
    idle           = 1'b0;
    done           = 1'b0;
    chip_select_n  = 1'b1;
    read_enable_n  = 1'b1;
    write_enable_n = 1'b1;
    data_bus_io    = 1'b0;
    case (state)
      ST_IDLE: idle = 1'b1;
      ST_SETUP: begin
        chip_select_n = 1'b0;
        data_bus_io   = write_q;
      end
      ST_STROBE: begin
        chip_select_n  = 1'b0;
        data_bus_io    = write_q;
        read_enable_n  = write_q;
        write_enable_n = !write_q;
      end
      ST_HOLD: begin
        chip_select_n = 1'b0;
        data_bus_io   = write_q;
      end
      ST_RECOVERY: done = (cnt == '0);
      default: idle = 1'b0;
    endcase
  end

  assign address      = address_q;
  assign data_bus_out = data_bus_io ? data_q : '0;

endmodule

// File: rtl/kf8259_host_bus_master.sv
// CPU-side initiator for the 8259 register bus: arbitrates single commands
// against the ICW initialization sequencer and drives one bus-cycle timer.
module kf8259_host_bus_master
  import kf8259_host_pkg::*;
#(
  parameter int SETUP_CYCLES    = 1,
  parameter int STROBE_CYCLES   = 2,
  parameter int HOLD_CYCLES     = 1,
  parameter int RECOVERY_CYCLES = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_write,
  input  logic       cmd_address,
  input  logic [7:0] cmd_data,
  input  logic       init_start,
  input  logic [7:0] icw1,
  input  logic [7:0] icw2,
  input  logic [7:0] icw3,
  input  logic [7:0] icw4,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       busy,
  output logic       init_done,
  output logic       chip_select_n,
  output logic       read_enable_n,
  output logic       write_enable_n,
  output logic       address,
  output logic [7:0] data_bus_out,
  output logic       data_bus_io,
  input  logic [7:0] data_bus_in
);

  logic       cycle_idle, cycle_done;
  logic       init_active;
  init_step_t step;
  logic [7:0] icw1_q, icw2_q, icw3_q, icw4_q;
  logic       init_accept, init_issue, cmd_accept;
  logic       start, start_write, start_address;
  logic [7:0] start_data, icw_word;
  logic       icw_a0;

  // Init wins over a simultaneous command; neither is taken while anything is in flight.
  assign init_accept = init_start && cycle_idle && !init_active && !reset;
  assign cmd_ready   = cycle_idle && !init_active && !init_start && !reset;
  assign cmd_accept  = cmd_valid && cmd_ready;
  assign init_issue  = init_active && (step != STEP_DONE) && cycle_idle;
  assign init_done   = init_active && (step == STEP_DONE) && cycle_idle;
  assign busy        = !cycle_idle || init_active;

  // ICW sequencer: latch words at start, advance as each write completes.
  always_ff @(posedge clock) begin
    if (reset) begin
      init_active <= 1'b0;
      step        <= STEP_ICW1;
      icw1_q      <= '0;
      icw2_q      <= '0;
      icw3_q      <= '0;
      icw4_q      <= '0;
    end else if (init_accept) begin
      init_active <= 1'b1;
      step        <= STEP_ICW1;
      icw1_q      <= icw1 | 8'(1 << ICW1_ID);
      icw2_q      <= icw2;
      icw3_q      <= icw3;
      icw4_q      <= icw4;
    end else if (init_done) begin
      init_active <= 1'b0;
    end else if (init_active && cycle_done) begin
      step <= next_init_step(step, icw1_q);
    end
  end

  // Select the ICW byte and A0 for the current sequencer step.
  always_comb begin
    icw_word = icw1_q;
    icw_a0   = 1'b0;
    case (step)
      STEP_ICW2: begin icw_word = icw2_q; icw_a0 = 1'b1; end
      STEP_ICW3: begin icw_word = icw3_q; icw_a0 = 1'b1; end
      STEP_ICW4: begin icw_word = icw4_q; icw_a0 = 1'b1; end
      default:   begin icw_word = icw1_q; icw_a0 = 1'b0; end
    endcase
  end

  assign start         = init_issue || cmd_accept;
  assign start_write   = init_issue ? 1'b1 : cmd_write;
  assign start_address = init_issue ? icw_a0 : cmd_address;
  assign start_data    = init_issue ? icw_word : cmd_data;

  kf8259_host_bus_cycle #(
    .SETUP_CYCLES   (SETUP_CYCLES),
    .STROBE_CYCLES  (STROBE_CYCLES),
    .HOLD_CYCLES    (HOLD_CYCLES),
    .RECOVERY_CYCLES(RECOVERY_CYCLES)
  ) u_cycle (
    .clock         (clock),
    .reset         (reset),
    .start         (start),
    .start_write   (start_write),
    .start_address (start_address),
    .start_data    (start_data),
    .idle          (cycle_idle),
    .done          (cycle_done),
    .chip_select_n (chip_select_n),
    .read_enable_n (read_enable_n),
    .write_enable_n(write_enable_n),
    .address       (address),
    .data_bus_out  (data_bus_out),
    .data_bus_io   (data_bus_io),
    .rsp_valid     (rsp_valid),
    .rsp_data      (rsp_data),
    .data_bus_in   (data_bus_in)
  );

endmodule

// File: tb/tb_kf8259_host_bus_master.sv
// Bench for kf8259_host_bus_master: directed stimulus, expected writes and
// read responses queued at issue, popped by a bus-side 8259 monitor.
module tb_kf8259_host_bus_master;

  logic       clock = 1'b0;
  logic       reset;
  logic       cmd_valid, cmd_write, cmd_address;
  logic [7:0] cmd_data;
  logic       cmd_ready;
  logic       init_start;
  logic [7:0] icw1, icw2, icw3, icw4;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       busy, init_done;
  logic       chip_select_n, read_enable_n, write_enable_n, address;
  logic [7:0] data_bus_out, data_bus_in;
  logic       data_bus_io;

  typedef struct {
    logic       a0;
    logic [7:0] d;
  } wr_t;

  wr_t        exp_wr[$];
  logic [7:0] exp_rd[$];
  int         total = 0;
  int         bad = 0;
  int         done_seen = 0;
  int         exp_done = 0;
  logic       wr_prev = 1'b1;
  wr_t        mon_w;
  logic [7:0] mon_r;

  always #5 clock = ~clock;

  kf8259_host_bus_master dut (
    .clock         (clock),
    .reset         (reset),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_write     (cmd_write),
    .cmd_address   (cmd_address),
    .cmd_data      (cmd_data),
    .init_start    (init_start),
    .icw1          (icw1),
    .icw2          (icw2),
    .icw3          (icw3),
    .icw4          (icw4),
    .rsp_valid     (rsp_valid),
    .rsp_data      (rsp_data),
    .busy          (busy),
    .init_done     (init_done),
    .chip_select_n (chip_select_n),
    .read_enable_n (read_enable_n),
    .write_enable_n(write_enable_n),
    .address       (address),
    .data_bus_out  (data_bus_out),
    .data_bus_io   (data_bus_io),
    .data_bus_in   (data_bus_in)
  );

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // 8259-side monitor: a write is WR_n rising while CS_n is low; A0/data sampled there.
  always @(negedge clock) begin
    if (!reset) begin
      if (!wr_prev && write_enable_n && !chip_select_n) begin
        if (exp_wr.size() == 0) check("unexpected_write", 1, 0);
        else begin
          mon_w = exp_wr.pop_front();
          check("write_a0", {31'd0, address}, {31'd0, mon_w.a0});
          check("write_data", {24'd0, data_bus_out}, {24'd0, mon_w.d});
        end
      end
      if (rsp_valid) begin
        if (exp_rd.size() == 0) check("unexpected_rsp", 1, 0);
        else begin
          mon_r = exp_rd.pop_front();
          check("rsp_data", {24'd0, rsp_data}, {24'd0, mon_r});
        end
      end
      if (init_done) done_seen++;
    end
    wr_prev = write_enable_n;
  end

  task automatic check_idle_bus(input string tag);
    check({tag, "_cs_n"}, {31'd0, chip_select_n}, 1);
    check({tag, "_rd_n"}, {31'd0, read_enable_n}, 1);
    check({tag, "_wr_n"}, {31'd0, write_enable_n}, 1);
    check({tag, "_io"}, {31'd0, data_bus_io}, 0);
    check({tag, "_busy"}, {31'd0, busy}, 0);
    check({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 0);
  endtask

  // Present a command and hold it until accepted (bounded).
  task automatic send_cmd(input logic w, input logic a, input logic [7:0] d);
    @(negedge clock);
    cmd_valid = 1'b1; cmd_write = w; cmd_address = a; cmd_data = d;
    for (int i = 0; i < 200; i++) begin
      if (cmd_ready) break;
      @(negedge clock);
    end
    check("cmd_accept_timeout", {31'd0, cmd_ready}, 1);
    @(posedge clock);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic run_init(input logic [7:0] w1, input logic [7:0] w2,
                          input logic [7:0] w3, input logic [7:0] w4);
    @(negedge clock);
    icw1 = w1; icw2 = w2; icw3 = w3; icw4 = w4; init_start = 1'b1;
    @(posedge clock);
    #1 init_start = 1'b0;
    exp_done++;
  endtask

  task automatic wait_init;
    for (int i = 0; i < 300; i++) begin
      if (done_seen >= exp_done) break;
      @(negedge clock);
    end
    check("init_done_count", done_seen, exp_done);
  endtask

  // Per-cycle expectations for cycles 1..5 after accept.
  logic       cs_pat[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  logic       stb_pat[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
  logic       wio_pat[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  logic       rv_pat[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_address = 1'b0;
    cmd_data = '0; init_start = 1'b0; icw1 = '0; icw2 = '0; icw3 = '0; icw4 = '0;
    data_bus_in = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_idle_bus("reset");
    check("reset_cmd_ready", {31'd0, cmd_ready}, 0);
    check("reset_addr", {31'd0, address}, 0);
    check("reset_dout", {24'd0, data_bus_out}, 0);
    check("reset_init_done", {31'd0, init_done}, 0);
    reset = 1'b0;
    @(negedge clock);
    check("idle_cmd_ready", {31'd0, cmd_ready}, 1);

    // Write A0=0 0x13, traced cycle by cycle.
    exp_wr.push_back('{a0: 1'b0, d: 8'h13});
    send_cmd(1'b1, 1'b0, 8'h13);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check($sformatf("wr_cs_c%0d", i + 1), {31'd0, chip_select_n}, {31'd0, cs_pat[i]});
      check($sformatf("wr_wr_c%0d", i + 1), {31'd0, write_enable_n}, {31'd0, stb_pat[i]});
      check($sformatf("wr_rd_c%0d", i + 1), {31'd0, read_enable_n}, 1);
      check($sformatf("wr_io_c%0d", i + 1), {31'd0, data_bus_io}, {31'd0, wio_pat[i]});
      check($sformatf("wr_busy_c%0d", i + 1), {31'd0, busy}, 1);
      if (i < 4) begin
        check($sformatf("wr_a0_c%0d", i + 1), {31'd0, address}, 0);
        check($sformatf("wr_dout_c%0d", i + 1), {24'd0, data_bus_out}, 32'h13);
      end
    end
    @(negedge clock);
    check("wr_end_busy", {31'd0, busy}, 0);

    // Read A0=1 returning 0xA5.
    data_bus_in = 8'hA5;
    exp_rd.push_back(8'hA5);
    send_cmd(1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check($sformatf("rd_cs_c%0d", i + 1), {31'd0, chip_select_n}, {31'd0, cs_pat[i]});
      check($sformatf("rd_rd_c%0d", i + 1), {31'd0, read_enable_n}, {31'd0, stb_pat[i]});
      check($sformatf("rd_wr_c%0d", i + 1), {31'd0, write_enable_n}, 1);
      check($sformatf("rd_io_c%0d", i + 1), {31'd0, data_bus_io}, 0);
      check($sformatf("rd_rv_c%0d", i + 1), {31'd0, rsp_valid}, {31'd0, rv_pat[i]});
      if (i < 4) check($sformatf("rd_a0_c%0d", i + 1), {31'd0, address}, 1);
    end
    data_bus_in = 8'h00;

    // Full sequence: cascade + IC4 -> four words.
    exp_wr.push_back('{a0: 1'b0, d: 8'h11});
    exp_wr.push_back('{a0: 1'b1, d: 8'h08});
    exp_wr.push_back('{a0: 1'b1, d: 8'h04});
    exp_wr.push_back('{a0: 1'b1, d: 8'h01});
    run_init(8'h11, 8'h08, 8'h04, 8'h01);
    wait_init();
    check("init4_pending_writes", exp_wr.size(), 0);

    // Single, no IC4 -> two words.
    exp_wr.push_back('{a0: 1'b0, d: 8'h12});
    exp_wr.push_back('{a0: 1'b1, d: 8'h20});
    run_init(8'h12, 8'h20, 8'hEE, 8'hDD);
    wait_init();
    check("init2_pending_writes", exp_wr.size(), 0);

    // ICW1 without bit4 -> bus shows it forced.
    exp_wr.push_back('{a0: 1'b0, d: 8'h12});
    exp_wr.push_back('{a0: 1'b1, d: 8'h28});
    run_init(8'h02, 8'h28, 8'hFF, 8'hFF);
    wait_init();
    check("init_id_pending_writes", exp_wr.size(), 0);

    // init_start and cmd_valid together: init first, command after init_done.
    @(negedge clock);
    icw1 = 8'h13; icw2 = 8'h40; icw3 = 8'h00; icw4 = 8'h03; init_start = 1'b1;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_address = 1'b1; cmd_data = 8'h5A;
    exp_wr.push_back('{a0: 1'b0, d: 8'h13});
    exp_wr.push_back('{a0: 1'b1, d: 8'h40});
    exp_wr.push_back('{a0: 1'b1, d: 8'h03});
    exp_wr.push_back('{a0: 1'b1, d: 8'h5A});
    exp_done++;
    #1 check("simul_cmd_ready", {31'd0, cmd_ready}, 0);
    @(posedge clock);
    #1 init_start = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clock);
      if (cmd_ready) break;
    end
    check("simul_ready_after_init", {31'd0, cmd_ready}, 1);
    check("simul_init_done_first", done_seen, exp_done);
    @(posedge clock);
    #1 cmd_valid = 1'b0;
    repeat (8) @(negedge clock);
    check("simul_pending_writes", exp_wr.size(), 0);

    // init_start while a command is running is ignored.
    exp_wr.push_back('{a0: 1'b0, d: 8'h77});
    send_cmd(1'b1, 1'b0, 8'h77);
    @(negedge clock);
    check("busy_during_cmd", {31'd0, busy}, 1);
    icw1 = 8'h11; init_start = 1'b1;
    @(posedge clock);
    #1 init_start = 1'b0;
    repeat (30) @(negedge clock);
    check("ignored_init_done", done_seen, exp_done);
    check("ignored_pending_writes", exp_wr.size(), 0);

    // Reset in the middle of a read strobe: abandoned, no response.
    data_bus_in = 8'h99;
    send_cmd(1'b0, 1'b0, 8'h00);
    @(negedge clock);
    @(negedge clock);
    check("pre_reset_rd_strobe", {31'd0, read_enable_n}, 0);
    reset = 1'b1;
    @(posedge clock);
    #1;
    check_idle_bus("midreset");
    @(negedge clock);
    reset = 1'b0;
    repeat (6) @(negedge clock);

    // Recovery after reset: a normal read still works.
    data_bus_in = 8'h3C;
    exp_rd.push_back(8'h3C);
    send_cmd(1'b0, 1'b0, 8'h00);
    repeat (8) @(negedge clock);

    check("final_pending_writes", exp_wr.size(), 0);
    check("final_pending_reads", exp_rd.size(), 0);
    check("final_init_done", done_seen, exp_done);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global guard so the run always terminates.
  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout want completion");
    $fatal(1, "timeout");
  end

endmodule
